// File: rtl/uart_tx_arb.sv
// uart_tx_arb
//   Four-way round-robin arbiter in front of a single UART transmitter.
//   A requester may hold req_lock to keep ownership for consecutive bytes,
//   limited to MAX_BURST bytes before ownership is forced to rotate.  Each
//   byte waits in WAIT for the transmitter's tx_done, bounded by a
//   TIMEOUT_CYC watchdog.
//
// Ports
//   clk          single clock, posedge
//   rst_n        asynchronous active-low reset
//   req[3:0]     per-requester byte request
//   req_lock[3:0] keep ownership for the next byte (qualified by req)
//   req_data[31:0] byte i in bits [8i+7:8i]
//   gnt[3:0]     one-hot, one-cycle acceptance pulse
//   tx_start     one-cycle launch pulse to the transmitter
//   tx_data[7:0] byte under transmission, held through WAIT
//   tx_done      transmitter frame-complete pulse
//   owner[1:0]   current or last granted requester
//   busy         high from grant until tx_done or timeout
//   err_timeout  one-cycle pulse on a transmission timeout
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transfer; pick a round-robin winner when any req is high
// ISSUE | gnt/tx_start asserted for one cycle, byte held on tx_data
// WAIT  | watchdog running; leave on tx_done (lock or rotate) or timeout

module uart_tx_arb #(
   parameter int TIMEOUT_CYC = 9548,
   parameter int MAX_BURST   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req,
   input  logic [3:0]  req_lock,
   input  logic [31:0] req_data,
   output logic [3:0]  gnt,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_done,
   output logic [1:0]  owner,
   output logic        busy,
   output logic        err_timeout
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int BW = $clog2(MAX_BURST + 1);

   // Watchdog is a down-counter: loaded with TIMEOUT_CYC-1 on entering
   // WAIT so terminal count lands exactly TIMEOUT_CYC clocks later.
   localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYC - 1);
   localparam logic [BW-1:0] BURST_MAX    = BW'(MAX_BURST);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      gnt_q, gnt_d;
   logic            tx_start_q, tx_start_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic [1:0]      owner_q, owner_d;
   logic            busy_q, busy_d;
   logic            err_timeout_q, err_timeout_d;
   logic [1:0]      ptr_q, ptr_d;
   logic [BW-1:0]   burst_q, burst_d;
   logic [TW-1:0]   cnt_q, cnt_d;

   logic [1:0]      rr_win;
   logic [1:0]      rr_idx;
   logic            lock_ok;
   logic            do_grant;
   logic            do_rotate;
   logic [1:0]      grant_idx;

   // Round-robin pick: scan offsets high to low so the lowest offset from
   // ptr that has a request is the last (winning) assignment.
   always_comb begin
      rr_win = ptr_q;
      rr_idx = '0;
      for (int i = 3; i >= 0; i--) begin
         rr_idx = ptr_q + 2'(i);
         if (req[rr_idx]) begin
            rr_win = rr_idx;
         end
      end
   end

   assign lock_ok = req[owner_q] && req_lock[owner_q] && (burst_q < BURST_MAX);

   always_comb begin
      state_d       = state_q;
      gnt_d         = '0;
      tx_start_d    = 1'b0;
      err_timeout_d = 1'b0;
      tx_data_d     = tx_data_q;
      owner_d       = owner_q;
      busy_d        = busy_q;
      ptr_d         = ptr_q;
      burst_d       = burst_q;
      cnt_d         = cnt_q;
      do_grant      = 1'b0;
      do_rotate     = 1'b0;
      grant_idx     = owner_q;

      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               do_grant  = 1'b1;
               grant_idx = rr_win;
               burst_d   = BW'(1);
            end
         end
         ST_ISSUE: begin
            // tx_done here belongs to an earlier frame and is ignored.
            state_d = ST_WAIT;
            cnt_d   = TIMEOUT_LOAD;
         end
         ST_WAIT: begin
            if (tx_done) begin
               if (lock_ok) begin
                  do_grant  = 1'b1;
                  grant_idx = owner_q;
                  burst_d   = burst_q + BW'(1);
               end else begin
                  do_rotate = 1'b1;
               end
            end else if (cnt_q == '0) begin
               err_timeout_d = 1'b1;
               do_rotate     = 1'b1;
            end else begin
               cnt_d = cnt_q - TW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (do_grant) begin
         state_d    = ST_ISSUE;
         gnt_d      = 4'b0001 << grant_idx;
         tx_start_d = 1'b1;
         tx_data_d  = req_data[{grant_idx, 3'b000} +: 8];
         owner_d    = grant_idx;
         busy_d     = 1'b1;
      end

      if (do_rotate) begin
         state_d = ST_IDLE;
         ptr_d   = owner_q + 2'd1;
         burst_d = '0;
         busy_d  = 1'b0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         gnt_q         <= '0;
         tx_start_q    <= 1'b0;
         tx_data_q     <= '0;
         owner_q       <= '0;
         busy_q        <= 1'b0;
         err_timeout_q <= 1'b0;
         ptr_q         <= '0;
         burst_q       <= '0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         gnt_q         <= gnt_d;
         tx_start_q    <= tx_start_d;
         tx_data_q     <= tx_data_d;
         owner_q       <= owner_d;
         busy_q        <= busy_d;
         err_timeout_q <= err_timeout_d;
         ptr_q         <= ptr_d;
         burst_q       <= burst_d;
         cnt_q         <= cnt_d;
      end
   end

   assign gnt         = gnt_q;
   assign tx_start    = tx_start_q;
   assign tx_data     = tx_data_q;
   assign owner       = owner_q;
   assign busy        = busy_q;
   assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb
//   Bench for uart_tx_arb.  Expected grants (requester, byte) are queued as
//   requests are driven and popped by a monitor whenever tx_start/gnt fires.
//   The watchdog is set above the 4340-clock frame so one instance covers
//   both the long single-frame case and the timeout case.

module tb_uart_tx_arb;

   localparam int TO = 4400;
   localparam int MB = 3;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [3:0]  req_lock;
   logic [31:0] req_data;
   logic [3:0]  gnt;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_done;
   logic [1:0]  owner;
   logic        busy;
   logic        err_timeout;

   typedef struct {
      logic [1:0] idx;
      logic [7:0] data;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;
   logic prev_gnt = 1'b0;
   logic prev_err = 1'b0;

   uart_tx_arb #(.TIMEOUT_CYC(TO), .MAX_BURST(MB)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .req_lock    (req_lock),
      .req_data    (req_data),
      .gnt         (gnt),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_done     (tx_done),
      .owner       (owner),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [1:0] idx, input logic [7:0] data);
      exp_t e;
      e.idx  = idx;
      e.data = data;
      sb_q.push_back(e);
   endtask

   // Scoreboard monitor: every launch must match the oldest expected grant.
   always @(negedge clk) begin
      if (rst_n) begin
         if (gnt != 4'b0000 || tx_start) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_gnt", {27'd0, gnt, tx_start}, 32'd0);
            end else begin
               mon_e = sb_q.pop_front();
               chk("gnt", {28'd0, gnt}, 32'(4'b0001 << mon_e.idx));
               chk("tx_start", {31'd0, tx_start}, 32'd1);
               chk("tx_data", {24'd0, tx_data}, {24'd0, mon_e.data});
               chk("owner", {30'd0, owner}, {30'd0, mon_e.idx});
               chk("busy_at_issue", {31'd0, busy}, 32'd1);
            end
            if (prev_gnt) begin
               chk("gnt_back_to_back", 32'd1, 32'd0);
            end
         end
         if (err_timeout && prev_err) begin
            chk("err_two_cycles", 32'd1, 32'd0);
         end
         prev_gnt = (gnt != 4'b0000);
         prev_err = err_timeout;
      end else begin
         prev_gnt = 1'b0;
         prev_err = 1'b0;
      end
   end

   // Returns at the negedge of the ISSUE cycle; lat counts negedges waited.
   task automatic wait_start(output int lat);
      bit found;
      found = 1'b0;
      lat   = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         lat++;
         if (tx_start) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) begin
         chk("tx_start_seen", 32'd0, 32'd1);
      end
   endtask

   task automatic pulse_done_after(input int n);
      repeat (n) @(posedge clk);
      #1 tx_done = 1'b1;
      @(posedge clk);
      #1 tx_done = 1'b0;
   endtask

   task automatic check_all_zero(input string pfx);
      chk({pfx, "_gnt"}, {28'd0, gnt}, 32'd0);
      chk({pfx, "_tx_start"}, {31'd0, tx_start}, 32'd0);
      chk({pfx, "_tx_data"}, {24'd0, tx_data}, 32'd0);
      chk({pfx, "_owner"}, {30'd0, owner}, 32'd0);
      chk({pfx, "_busy"}, {31'd0, busy}, 32'd0);
      chk({pfx, "_err"}, {31'd0, err_timeout}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed no finish expected finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      int lat;
      int cnt;
      bit seen;
      rst_n    = 1'b0;
      req      = '0;
      req_lock = '0;
      req_data = '0;
      tx_done  = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Round robin from ptr=0: 0,1,2,3,0
      @(posedge clk);
      #1 req = 4'b1111;
      req_data = 32'h1312_1110;
      push_exp(2'd0, 8'h10);
      push_exp(2'd1, 8'h11);
      push_exp(2'd2, 8'h12);
      push_exp(2'd3, 8'h13);
      push_exp(2'd0, 8'h10);
      for (int k = 0; k < 5; k++) begin
         wait_start(lat);
         chk(k == 0 ? "lat_first" : "lat_rotate", lat, (k == 0) ? 32'd2 : 32'd2);
         if (k == 4) begin
            @(posedge clk);
            #1 req = '0;
            pulse_done_after(1);
         end else begin
            pulse_done_after(2);
         end
      end

      // Single request, 4340-clock frame, request dropped during WAIT (ptr=1 here)
      @(posedge clk);
      #1 req = 4'b0001;
      req_data = 32'h0000_0042;
      push_exp(2'd0, 8'h42);
      wait_start(lat);
      @(posedge clk);
      #1 req = '0;
      req_data = 32'h0000_00EE;
      repeat (4338) @(posedge clk);
      @(negedge clk);
      chk("single_busy_held", {31'd0, busy}, 32'd1);
      chk("single_data_held", {24'd0, tx_data}, 32'h42);
      @(posedge clk);
      #1 tx_done = 1'b1;
      @(posedge clk);
      #1 tx_done = 1'b0;
      @(negedge clk);
      chk("single_busy_clear", {31'd0, busy}, 32'd0);

      // ptr=1 after single: req 1001 must go to 3 first, then 0
      @(posedge clk);
      #1 req = 4'b1001;
      req_data = 32'hA300_0055;
      push_exp(2'd3, 8'hA3);
      push_exp(2'd0, 8'h55);
      wait_start(lat);
      pulse_done_after(3);
      wait_start(lat);
      chk("lat_rotate_ptr", lat, 32'd2);
      @(posedge clk);
      #1 req = '0;
      pulse_done_after(2);

      // Lock burst: requester 2 locked (ptr=1), requester 0 waiting
      @(posedge clk);
      #1 req = 4'b0101;
      req_lock = 4'b0100;
      req_data = 32'h00B0_005A;
      push_exp(2'd2, 8'hB0);
      push_exp(2'd2, 8'hB1);
      push_exp(2'd2, 8'hB2);
      push_exp(2'd0, 8'h5A);
      wait_start(lat);
      for (int k = 1; k < 3; k++) begin
         @(posedge clk);
         #1 req_data[23:16] = 8'hB0 + 8'(k);
         pulse_done_after(2);
         wait_start(lat);
         chk("lat_lock", lat, 32'd1);
      end
      pulse_done_after(2);
      wait_start(lat);
      chk("lat_burst_rotate", lat, 32'd2);
      @(posedge clk);
      #1 req = '0;
      req_lock = '0;
      pulse_done_after(1);

      // Timeout on requester 1 (ptr=1); next grant must rotate to 3
      @(posedge clk);
      #1 req = 4'b1010;
      req_data = 32'hC300_C100;
      push_exp(2'd1, 8'hC1);
      push_exp(2'd3, 8'hC3);
      wait_start(lat);
      cnt  = 0;
      seen = 1'b0;
      for (int i = 0; i < TO + 10; i++) begin
         @(negedge clk);
         cnt++;
         if (err_timeout) begin
            seen = 1'b1;
            break;
         end
      end
      chk("timeout_seen", {31'd0, seen}, 32'd1);
      chk("timeout_cycles", cnt - 1, TO);
      chk("timeout_busy", {31'd0, busy}, 32'd0);
      wait_start(lat);
      chk("timeout_err_one_cycle", {31'd0, err_timeout}, 32'd0);
      @(posedge clk);
      #1 req = '0;
      pulse_done_after(2);

      // Stale tx_done during ISSUE (ptr=0)
      @(posedge clk);
      #1 req = 4'b0001;
      req_data = 32'h0000_00D0;
      push_exp(2'd0, 8'hD0);
      wait_start(lat);
      tx_done = 1'b1;
      @(posedge clk);
      #1 tx_done = 1'b0;
      req = '0;
      repeat (5) @(negedge clk);
      chk("stale_busy", {31'd0, busy}, 32'd1);
      chk("stale_data", {24'd0, tx_data}, 32'hD0);
      pulse_done_after(1);
      @(negedge clk);
      chk("stale_busy_clear", {31'd0, busy}, 32'd0);

      // Reset in the middle of WAIT (ptr=1)
      @(posedge clk);
      #1 req = 4'b0010;
      req_data = 32'h0000_7700;
      push_exp(2'd1, 8'h77);
      wait_start(lat);
      @(posedge clk);
      #1 req = '0;
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_all_zero("midreset");
      req = 4'b0100;
      req_data = 32'h009C_0000;
      push_exp(2'd2, 8'h9C);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_start(lat);
      chk("lat_after_reset", lat, 32'd2);
      @(posedge clk);
      #1 req = '0;
      pulse_done_after(2);
      @(negedge clk);
      chk("final_busy", {31'd0, busy}, 32'd0);
      chk("sb_empty", sb_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
